// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        OPEN  = 3'd2,
        DENY  = 3'd3,
        PEND  = 3'd4
    } lane_state_t;

    localparam int GATE_TIMEOUT_DEF = 1000;
    localparam int DENY_CYCLES_DEF  = 16;
    localparam int TIMER_W_DEF      = 16;

endpackage

// File: rtl/parking_lane_fsm.sv
// One barrier lane: latches the car class, checks vacancy once, opens the
// barrier, waits for the pass sensor and then requests an event pulse.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF,
    parameter int DENY_CYCLES  = DENY_CYCLES_DEF,
    parameter int TIMER_W      = TIMER_W_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic arrive_i,
    input  logic is_uni_i,
    input  logic pass_i,
    input  logic uni_vac_i,
    input  logic vac_i,
    input  logic pulse_grant_i,
    output logic gate_open_o,
    output logic denied_o,
    output logic pulse_req_o,
    output logic cls_o
);

    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(GATE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DENY_LAST = TIMER_W'(DENY_CYCLES - 1);

    lane_state_t        state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               cls_q;
    logic               gate_q;
    logic               denied_q;
    logic               req_q;

    // Saturating increment: the timer holds at all-ones instead of wrapping.
    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (v == {TIMER_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Lane state machine with registered barrier/refusal/request outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cls_q    <= 1'b0;
            gate_q   <= 1'b0;
            denied_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arrive_i) begin
                        cls_q   <= is_uni_i;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // Vacancy is only looked at here; later flag changes
                    // never revoke an open barrier.
                    timer_q <= '0;
                    if (cls_q ? uni_vac_i : vac_i) begin
                        gate_q  <= 1'b1;
                        state_q <= OPEN;
                    end else begin
                        denied_q <= 1'b1;
                        state_q  <= DENY;
                    end
                end
                OPEN: begin
                    if (pass_i) begin
                        gate_q  <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= PEND;
                    end else if (timer_q == TO_LAST) begin
                        gate_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= sat_inc(timer_q);
                    end
                end
                DENY: begin
                    if (timer_q == DENY_LAST) begin
                        denied_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= sat_inc(timer_q);
                    end
                end
                PEND: begin
                    // Stay here until the arbiter lets our pulse through.
                    if (pulse_grant_i) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gate_open_o = gate_q;
    assign denied_o    = denied_q;
    assign pulse_req_o = req_q;
    assign cls_o       = cls_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding the occupancy counter's event
// interface; at most one event pulse per cycle, entry first.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF,
    parameter int DENY_CYCLES  = DENY_CYCLES_DEF,
    parameter int TIMER_W      = TIMER_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_arrive,
    input  logic entry_is_uni,
    input  logic entry_pass,
    input  logic exit_arrive,
    input  logic exit_is_uni,
    input  logic exit_pass,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
);

    logic ent_gate, ent_denied, ent_req, ent_cls, ent_grant;
    logic ext_gate, ext_denied, ext_req, ext_cls, ext_grant;
    logic car_entered_q, uni_entered_q, car_exited_q, uni_exited_q;

    parking_lane_fsm #(
        .GATE_TIMEOUT(GATE_TIMEOUT), .DENY_CYCLES(DENY_CYCLES), .TIMER_W(TIMER_W)
    ) u_entry (
        .clk_i(clk), .reset_i(reset),
        .arrive_i(entry_arrive), .is_uni_i(entry_is_uni), .pass_i(entry_pass),
        .uni_vac_i(uni_is_vacated_space), .vac_i(is_vacated_space),
        .pulse_grant_i(ent_grant),
        .gate_open_o(ent_gate), .denied_o(ent_denied),
        .pulse_req_o(ent_req), .cls_o(ent_cls)
    );

    // The exit lane always has room, so it always grants.
    parking_lane_fsm #(
        .GATE_TIMEOUT(GATE_TIMEOUT), .DENY_CYCLES(DENY_CYCLES), .TIMER_W(TIMER_W)
    ) u_exit (
        .clk_i(clk), .reset_i(reset),
        .arrive_i(exit_arrive), .is_uni_i(exit_is_uni), .pass_i(exit_pass),
        .uni_vac_i(1'b1), .vac_i(1'b1),
        .pulse_grant_i(ext_grant),
        .gate_open_o(ext_gate), .denied_o(ext_denied),
        .pulse_req_o(ext_req), .cls_o(ext_cls)
    );

    // Fixed-priority arbiter: the counter drops same-cycle entry+exit, so
    // a pending exit waits one cycle behind an entry.
    always_comb begin
        ent_grant = ent_req;
        ext_grant = ext_req & ~ent_req;
    end

    // Event pulse registers; class bits are forced low without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_entered_q <= 1'b0;
            uni_entered_q <= 1'b0;
            car_exited_q  <= 1'b0;
            uni_exited_q  <= 1'b0;
        end else begin
            car_entered_q <= ent_grant;
            uni_entered_q <= ent_grant & ent_cls;
            car_exited_q  <= ext_grant;
            uni_exited_q  <= ext_grant & ext_cls;
        end
    end

    assign car_entered        = car_entered_q;
    assign is_uni_car_entered = uni_entered_q;
    assign car_exited         = car_exited_q;
    assign is_uni_car_exited  = uni_exited_q;
    assign entry_gate_open    = ent_gate;
    assign exit_gate_open     = ext_gate;
    // Exit lane vacancy is tied high, so its refusal term is constant 0.
    assign entry_denied       = ent_denied | ext_denied;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a pulse scoreboard.
module tb_parking_gate_ctrl;

    logic clk = 1'b0;
    logic reset, entry_arrive, entry_is_uni, entry_pass;
    logic exit_arrive, exit_is_uni, exit_pass;
    logic uni_is_vacated_space, is_vacated_space;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_gate_open, exit_gate_open, entry_denied;

    typedef struct {
        logic ex;
        logic uni;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    parking_gate_ctrl #(.GATE_TIMEOUT(1000), .DENY_CYCLES(16), .TIMER_W(16)) dut (
        .clk(clk), .reset(reset),
        .entry_arrive(entry_arrive), .entry_is_uni(entry_is_uni), .entry_pass(entry_pass),
        .exit_arrive(exit_arrive), .exit_is_uni(exit_is_uni), .exit_pass(exit_pass),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .entry_denied(entry_denied)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lat = cycles from now (pass driven after this edge) to the pulse edge
    task automatic push(input logic ex, input logic uni, input int lat);
        exp_t e;
        e.ex  = ex;
        e.uni = uni;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        n_vec++;
        assert (car_entered || !is_uni_car_entered) else begin
            n_bad++;
            $error("FAIL uni_entered_without_pulse: observed %b expected 0", is_uni_car_entered);
        end
        n_vec++;
        assert (car_exited || !is_uni_car_exited) else begin
            n_bad++;
            $error("FAIL uni_exited_without_pulse: observed %b expected 0", is_uni_car_exited);
        end
        if (car_entered || car_exited) begin
            n_vec++;
            assert (!(car_entered && car_exited)) else begin
                n_bad++;
                $error("FAIL both_pulses cyc %0d: observed 1 1 expected one", cyc);
            end
            n_vec++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_pulse cyc %0d: observed ent=%b ext=%b expected none",
                       cyc, car_entered, car_exited);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                n_vec++;
                assert (car_exited === mon_e.ex && car_entered === !mon_e.ex) else begin
                    n_bad++;
                    $error("FAIL pulse_kind: observed ext=%b expected ext=%b", car_exited, mon_e.ex);
                end
                n_vec++;
                assert ((mon_e.ex ? is_uni_car_exited : is_uni_car_entered) === mon_e.uni) else begin
                    n_bad++;
                    $error("FAIL pulse_class: observed %b expected %b",
                           mon_e.ex ? is_uni_car_exited : is_uni_car_entered, mon_e.uni);
                end
                n_vec++;
                assert (cyc === mon_e.cyc) else begin
                    n_bad++;
                    $error("FAIL pulse_cycle: observed %0d expected %0d", cyc, mon_e.cyc);
                end
            end
        end
        if (sb.size() != 0) begin
            n_vec++;
            assert (sb[0].cyc >= cyc) else begin
                n_bad++;
                $error("FAIL missing_pulse: observed none by %0d expected at %0d", cyc, sb[0].cyc);
                mon_e = sb.pop_front();
            end
        end
    end

    initial begin
        int n_gate;
        int n_den;
        int n_xgate;
        reset = 1'b1;
        entry_arrive = 1'b0; entry_is_uni = 1'b0; entry_pass = 1'b0;
        exit_arrive = 1'b0;  exit_is_uni = 1'b0;  exit_pass = 1'b0;
        uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_car_entered", car_entered, 0);
        chk("rst_uni_entered", is_uni_car_entered, 0);
        chk("rst_car_exited", car_exited, 0);
        chk("rst_uni_exited", is_uni_car_exited, 0);
        chk("rst_entry_gate", entry_gate_open, 0);
        chk("rst_exit_gate", exit_gate_open, 0);
        chk("rst_denied", entry_denied, 0);
        reset = 1'b0;
        tick();

        // uni entry, pass 5 cycles after open; vacancy drop after open is ignored
        entry_arrive = 1'b1; entry_is_uni = 1'b1;
        tick();
        entry_arrive = 1'b0;
        chk("t1_gate_in_check", entry_gate_open, 0);
        tick();
        uni_is_vacated_space = 1'b0;
        n_gate = 0;
        for (int i = 0; i < 5; i++) begin
            if (entry_gate_open) n_gate++;
            if (i < 4) tick();
        end
        entry_pass = 1'b1;
        push(1'b0, 1'b1, 2);
        tick();
        entry_pass = 1'b0;
        chk("t1_gate_high_cycles", n_gate, 5);
        chk("t1_gate_closed", entry_gate_open, 0);
        repeat (4) tick();
        uni_is_vacated_space = 1'b1;

        // non-uni entry with no non-uni room: refused for 16 cycles
        is_vacated_space = 1'b0;
        entry_arrive = 1'b1; entry_is_uni = 1'b0;
        tick();
        entry_arrive = 1'b0;
        tick();
        n_den = 0; n_gate = 0;
        for (int i = 0; i < 20; i++) begin
            if (entry_denied) n_den++;
            if (entry_gate_open) n_gate++;
            tick();
        end
        chk("t2_denied_cycles", n_den, 16);
        chk("t2_gate_never", n_gate, 0);

        // uni entry with only non-uni room: refused
        is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
        entry_arrive = 1'b1; entry_is_uni = 1'b1;
        tick();
        entry_arrive = 1'b0;
        tick();
        chk("t2b_uni_denied", entry_denied, 1);
        chk("t2b_uni_gate", entry_gate_open, 0);
        repeat (20) tick();

        // non-uni entry with only non-uni room: granted, then timeout
        entry_arrive = 1'b1; entry_is_uni = 1'b0;
        tick();
        entry_arrive = 1'b0;
        tick();
        n_gate = 0;
        for (int i = 0; i < 1005; i++) begin
            if (entry_gate_open) n_gate++;
            tick();
        end
        chk("t3_timeout_open_cycles", n_gate, 1000);
        chk("t3_timeout_closed", entry_gate_open, 0);
        uni_is_vacated_space = 1'b1;
        tick();

        // entry and exit pass on the same edge
        entry_arrive = 1'b1; entry_is_uni = 1'b0;
        exit_arrive = 1'b1;  exit_is_uni = 1'b1;
        tick();
        entry_arrive = 1'b0; exit_arrive = 1'b0;
        tick();
        chk("t4_entry_gate", entry_gate_open, 1);
        chk("t4_exit_gate", exit_gate_open, 1);
        tick();
        entry_pass = 1'b1; exit_pass = 1'b1;
        push(1'b0, 1'b0, 2);
        push(1'b1, 1'b1, 3);
        tick();
        entry_pass = 1'b0; exit_pass = 1'b0;
        repeat (5) tick();

        // reset while entry gate open
        entry_arrive = 1'b1; entry_is_uni = 1'b1;
        tick();
        entry_arrive = 1'b0;
        tick();
        chk("t5_gate_before_reset", entry_gate_open, 1);
        reset = 1'b1;
        tick();
        chk("t5_gate_after_reset", entry_gate_open, 0);
        chk("t5_no_entered", car_entered, 0);
        reset = 1'b0;
        tick();
        entry_arrive = 1'b1; entry_is_uni = 1'b0;
        tick();
        entry_arrive = 1'b0;
        tick();
        chk("t5_rearrive_gate", entry_gate_open, 1);
        entry_pass = 1'b1;
        push(1'b0, 1'b0, 2);
        tick();
        entry_pass = 1'b0;
        repeat (4) tick();

        // uni exit
        exit_arrive = 1'b1; exit_is_uni = 1'b1;
        tick();
        exit_arrive = 1'b0;
        tick();
        n_xgate = 0;
        for (int i = 0; i < 3; i++) begin
            if (exit_gate_open) n_xgate++;
            if (i < 2) tick();
        end
        exit_pass = 1'b1;
        push(1'b1, 1'b1, 2);
        tick();
        exit_pass = 1'b0;
        chk("t6_exit_gate_cycles", n_xgate, 3);
        chk("t6_exit_gate_closed", exit_gate_open, 0);
        repeat (5) tick();

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
